// File: rtl/diferenciador_sat_pkg.sv
// rtl/diferenciador_sat_pkg.sv - shared Q5.15 format constants and control states for the differentiator
package diferenciador_sat_pkg;

  localparam int SIZE = 21;
  localparam int SIGN = 1;
  localparam int PF   = 15;
  localparam int MAG  = 5;

  localparam logic [SIZE-1:0] SAT_POS = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] SAT_NEG = {1'b1, {(SIZE-1){1'b0}}};
  localparam logic [SIZE-1:0] ONE     = SIZE'(32768);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/diferenciador_sat_restador.sv
// rtl/diferenciador_sat_restador.sv - combinational saturating subtractor D = A - B
module restador_sat
  import diferenciador_sat_pkg::*;
#(
  parameter int sign = SIGN,
  parameter int mag  = MAG,
  parameter int pf   = PF,
  parameter int size = sign + mag + pf
) (
  input  logic signed [size-1:0] A,
  input  logic signed [size-1:0] B,
  output logic signed [size-1:0] D,
  output logic                   ovf
);

  localparam logic [size-1:0] CLAMP_POS = {{sign{1'b0}}, {(size-sign){1'b1}}};
  localparam logic [size-1:0] CLAMP_NEG = {{sign{1'b1}}, {(size-sign){1'b0}}};

  logic [size-1:0] diff;

  always_comb begin
    diff = A - B;
    // Only operands of opposite sign can overflow; the wrapped result then flips away from A.
    ovf  = (A[size-1] != B[size-1]) && (diff[size-1] != A[size-1]);
    if (!ovf)
      D = diff;
    else if (A[size-1])
      D = CLAMP_NEG;
    else
      D = CLAMP_POS;
  end

endmodule

// File: rtl/diferenciador_sat.sv
// rtl/diferenciador_sat.sv - streaming first-difference stage with saturation and valid/ready handshakes
module diferenciador_sat
  import diferenciador_sat_pkg::*;
#(
  parameter int sign = SIGN,
  parameter int mag  = MAG,
  parameter int pf   = PF,
  parameter int size = sign + mag + pf,
  parameter int cntw = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic signed [size-1:0] X,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic signed [size-1:0] D,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   sat,
  output logic [cntw-1:0]        sat_cnt
);

  state_t state, state_nx;

  logic signed [size-1:0] prev;
  logic signed [size-1:0] prev_eff;
  logic signed [size-1:0] diff;
  logic                   ovf;
  logic                   accept;
  logic                   xfer;
  logic [cntw-1:0]        cnt_nx;

  assign valid_out = (state == FULL);
  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out;
  assign xfer      = valid_out && ready_in;
  assign prev_eff  = clr ? '0 : prev;

  restador_sat #(
    .sign(sign),
    .mag (mag),
    .pf  (pf),
    .size(size)
  ) u_restador (
    .A  (X),
    .B  (prev_eff),
    .D  (diff),
    .ovf(ovf)
  );

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (accept) state_nx = FULL;
      FULL:    if (xfer && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  // A clear in the accept cycle restarts the count from this sample's own overflow.
  always_comb begin
    cnt_nx = sat_cnt;
    if (clr)
      cnt_nx = ovf ? cntw'(1) : '0;
    else if (ovf && (sat_cnt != {cntw{1'b1}}))
      cnt_nx = sat_cnt + cntw'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      prev    <= '0;
      D       <= '0;
      sat     <= 1'b0;
      sat_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        D       <= diff;
        sat     <= ovf;
        prev    <= X;
        sat_cnt <= cnt_nx;
      end else if (clr) begin
        prev    <= '0;
        sat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_diferenciador_sat.sv
// tb/tb_diferenciador_sat.sv - scoreboard bench for diferenciador_sat using directed vectors
module tb_diferenciador_sat;
  import diferenciador_sat_pkg::*;

  typedef struct {
    int   d;
    logic s;
    int   c;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clr = 1'b0;
  logic signed [20:0] X = '0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic signed [20:0] D;
  logic              valid_out;
  logic              ready_in = 1'b1;
  logic              sat;
  logic [7:0]        sat_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  int   pushed = 0;

  localparam int POS = 1048575;
  localparam int NEG = -1048576;

  diferenciador_sat dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .X        (X),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .D        (D),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .sat      (sat),
    .sat_cnt  (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic send(input int x, input logic c, input int ed, input logic es, input int ec);
    int   n;
    logic acc;
    exp_t e;
    n   = 0;
    acc = 1'b0;
    X = x[20:0];
    valid_in = 1'b1;
    clr = c;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_out;
      if (acc) begin
        e.d = ed;
        e.s = es;
        e.c = ec;
        sb.push_back(e);
        pushed++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    valid_in = 1'b0;
    clr = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          popped++;
          chk("D", int'(D), e.d);
          chk("sat", int'(sat), int'(e.s));
          chk("sat_cnt", int'(sat_cnt), e.c);
        end
      end
    end
  end

  initial begin : stim
    int cnt;
    int x;
    int dexp;

    #12;
    chk("rst_D", int'(D), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    chk("rst_ready_out", int'(ready_out), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Stall an output, then pulse reset between clock edges.
    ready_in = 1'b0;
    send(123, 1'b0, 123, 1'b0, 0);
    @(posedge clk);
    #2;
    chk("stalled_valid_out", int'(valid_out), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_D", int'(D), 0);
    chk("async_rst_valid_out", int'(valid_out), 0);
    chk("async_rst_sat_cnt", int'(sat_cnt), 0);
    sb.delete();
    pushed--;
    #1;
    reset = 1'b0;
    ready_in = 1'b1;

    send(5, 1'b0, 5, 1'b0, 0);
    clr_pulse();

    send(int'(ONE), 1'b0, 32768, 1'b0, 0);
    send(98304, 1'b0, 65536, 1'b0, 0);
    send(65536, 1'b0, -32768, 1'b0, 0);
    clr_pulse();

    send(NEG, 1'b0, int'($signed(SAT_NEG)), 1'b0, 0);
    send(POS, 1'b0, int'(SAT_POS), 1'b1, 1);
    send(NEG, 1'b0, NEG, 1'b1, 2);

    cnt = 2;
    for (int i = 0; i < 300; i++) begin
      x    = (i % 2 == 0) ? POS : NEG;
      dexp = x;
      cnt  = (cnt < 255) ? cnt + 1 : 255;
      send(x, 1'b0, dexp, 1'b1, cnt);
    end

    // prev = -1048576 and its output is still presented; stall it.
    ready_in = 1'b0;
    fork
      begin
        send(7, 1'b0, POS, 1'b1, 255);
        send(9, 1'b0, 2, 1'b0, 255);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_D", int'(D), NEG);
          chk("bp_valid_out", int'(valid_out), 1);
          chk("bp_ready_out", int'(ready_out), 0);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
      end
    join

    send(1000, 1'b0, 991, 1'b0, 255);
    send(300, 1'b1, 300, 1'b0, 0);
    send(100, 1'b0, -200, 1'b0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("outputs_seen", popped, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
